// File: rtl/intrusion_event_uart_tx.sv
// intrusion_event_uart_tx
//   Watches the intrusion detector's status/zone LEDs and turns every change
//   of {alarm level, zone pattern} into a one-byte event. Events are queued
//   in a small FIFO and sent as UART frames.
//     event byte = {level[1:0], seq[1:0], zone[3:0]}
//     level      = tamper ? 3 : high_alert ? 2 : alert ? 1 : 0
//   Build option: define PARITY_EN to send 8E1 frames instead of 8N1.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   safe_led         detector SAFE status (informational, not encoded)
//   alert_led        detector ALERT status
//   high_alert_led   detector HIGH ALERT status
//   tamper_led       detector TAMPER status
//   zone_led[3:0]    detector active zones
//   uart_tx          serial event stream, idles high
//   tx_busy          high while a frame is on the line
//   fifo_overflow    sticky, set when an event was dropped on a full FIFO
module intrusion_event_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       safe_led,
  input  logic       alert_led,
  input  logic       high_alert_led,
  input  logic       tamper_led,
  input  logic [3:0] zone_led,
  output logic       uart_tx,
  output logic       tx_busy,
  output logic       fifo_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  // ---------------------------------------------------------------------
  // Event detection
  // ---------------------------------------------------------------------
  logic [1:0] level;
  logic [5:0] cur, snap;
  logic [1:0] seq;
  logic [7:0] ev_byte;

  logic       unused_safe;
  assign unused_safe = safe_led;

  always_comb begin
    level = 2'd0;
    if (tamper_led)          level = 2'd3;
    else if (high_alert_led) level = 2'd2;
    else if (alert_led)      level = 2'd1;
  end

  assign cur     = {level, zone_led};
  assign ev_byte = {level, seq, zone_led};

  // ---------------------------------------------------------------------
  // FIFO: pointers carry one wrap bit so full and empty are distinguishable
  // ---------------------------------------------------------------------
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, push;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // full comes from registered pointers, so a same-cycle pop never frees a slot
  assign push  = (cur != snap) && !full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap          <= '0;
      seq           <= '0;
      wr_ptr        <= '0;
      fifo_overflow <= 1'b0;
    end else if (cur != snap) begin
      // snapshot follows the inputs even on a drop so it is not re-detected
      snap <= cur;
      if (!full) begin
        wr_ptr <= wr_ptr + 1'b1;
        seq    <= seq + 2'd1;
      end else begin
        fifo_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= ev_byte;
  end

  // ---------------------------------------------------------------------
  // UART transmitter
  // ---------------------------------------------------------------------
`ifdef PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
`ifdef PARITY_EN
  logic          par;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      rd_ptr  <= '0;
      uart_tx <= 1'b1;
      tx_busy <= 1'b0;
`ifdef PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            shreg   <= mem[rd_ptr[AW-1:0]];
`ifdef PARITY_EN
            par     <= ^mem[rd_ptr[AW-1:0]];
`endif
            rd_ptr  <= rd_ptr + 1'b1;
            cnt     <= '0;
            uart_tx <= 1'b0;
            tx_busy <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          if (cnt == CNT_MAX) begin
            cnt     <= '0;
            bit_idx <= '0;
            uart_tx <= shreg[0];
            state   <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_MAX) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef PARITY_EN
              uart_tx <= par;
              state   <= PARITY;
`else
              uart_tx <= 1'b1;
              state   <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              uart_tx <= shreg[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef PARITY_EN
        PARITY: begin
          if (cnt == CNT_MAX) begin
            cnt     <= '0;
            uart_tx <= 1'b1;
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt == CNT_MAX) begin
            cnt     <= '0;
            tx_busy <= 1'b0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          uart_tx <= 1'b1;
          tx_busy <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
